// File: rtl/mcp3008_scan_sequencer.sv
// mcp3008_scan_sequencer: owns the MCP3008 SPI link, arbitrating on-demand conversions
// against a round-robin background scan and keeping a per-channel scan result table.
module mcp3008_scan_sequencer #(
    parameter int CLK_DIV     = 27,
    parameter int CS_HIGH_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [7:0]  ch_mask,
    input  logic        req_valid,
    input  logic [2:0]  req_ch,
    input  logic        req_diff,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ch,
    output logic [9:0]  rsp_data,
    output logic        rsp_src,
    output logic [79:0] scan_table,
    output logic [7:0]  scan_table_valid,
    output logic        busy,
    output logic        ad_clk,
    output logic        cs_n,
    output logic        din,
    input  logic        dout
);
    localparam int CMAX = CLK_DIV > CS_HIGH_CYC ? CLK_DIV : CS_HIGH_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GUARD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    hp;
    logic [4:0]    cmd;
    logic [9:0]    data;
    logic [2:0]    ch, ptr, scan_ch, sel_ch;
    logic          src, sel_sgl, div_end, guard_end;

    // first enabled channel at or after the pointer; lowest offset wins
    always_comb begin
        scan_ch = ptr;
        for (int i = 7; i >= 0; i--)
            if (ch_mask[ptr + 3'(i)]) scan_ch = ptr + 3'(i);
    end

    assign sel_ch    = req_valid ? req_ch : scan_ch;
    assign sel_sgl   = req_valid ? ~req_diff : 1'b1;
    assign div_end   = cnt == CW'(CLK_DIV - 1);
    assign guard_end = cnt == CW'(CS_HIGH_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            hp               <= '0;
            cmd              <= '0;
            data             <= '0;
            ch               <= '0;
            ptr              <= '0;
            src              <= 1'b0;
            req_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_ch           <= '0;
            rsp_data         <= '0;
            rsp_src          <= 1'b0;
            scan_table       <= '0;
            scan_table_valid <= '0;
            busy             <= 1'b0;
            ad_clk           <= 1'b0;
            cs_n             <= 1'b1;
            din              <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid || (scan_en && |ch_mask)) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        din       <= 1'b1;
                        cnt       <= '0;
                        src       <= req_valid;
                        ch        <= sel_ch;
                        cmd       <= {sel_sgl, sel_ch, 1'b0};
                    end
                end
                SETUP: begin
                    cnt <= div_end ? '0 : cnt + 1'b1;
                    if (div_end) begin
                        state  <= SHIFT;
                        ad_clk <= 1'b1;
                        hp     <= '0;
                    end
                end
                SHIFT: begin
                    cnt <= div_end ? '0 : cnt + 1'b1;
                    if (div_end && hp == 5'd31) begin
                        state     <= GUARD;
                        cs_n      <= 1'b1;
                        din       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_ch    <= ch;
                        rsp_data  <= data;
                        rsp_src   <= src;
                        if (!src) begin
                            for (int i = 0; i < 8; i++)
                                if (3'(i) == ch) scan_table[10*i +: 10] <= data;
                            scan_table_valid[ch] <= 1'b1;
                            ptr <= ch + 3'd1;
                        end
                    end else if (div_end) begin
                        hp     <= hp + 5'd1;
                        ad_clk <= hp[0];
                        // odd hp ends a low half: rising edge; B9..B0 arrive on edges 7..16
                        if (hp[0] && hp >= 5'd11) data <= {data[8:0], dout};
                        if (!hp[0]) begin
                            din <= cmd[4];
                            cmd <= {cmd[3:0], 1'b0};
                        end
                    end
                end
                GUARD: begin
                    cnt <= guard_end ? '0 : cnt + 1'b1;
                    if (guard_end) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcp3008_scan_sequencer.sv
// tb_mcp3008_scan_sequencer: MCP3008 device model plus a transaction-timing reference
// model compared against the sequencer outputs every cycle.
module tb_mcp3008_scan_sequencer;
    localparam int CD  = 2;
    localparam int CSH = 4;
    localparam int LOW = 33 * CD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic [7:0]  ch_mask;
    logic        req_valid;
    logic [2:0]  req_ch;
    logic        req_diff;
    logic        req_ready;
    logic        rsp_valid;
    logic [2:0]  rsp_ch;
    logic [9:0]  rsp_data;
    logic        rsp_src;
    logic [79:0] scan_table;
    logic [7:0]  scan_table_valid;
    logic        busy;
    logic        ad_clk;
    logic        cs_n;
    logic        din;
    logic        dout = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [9:0] vals [16];

    mcp3008_scan_sequencer #(.CLK_DIV(CD), .CS_HIGH_CYC(CSH)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_ch(req_ch), .req_diff(req_diff), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_src(rsp_src),
        .scan_table(scan_table), .scan_table_valid(scan_table_valid), .busy(busy),
        .ad_clk(ad_clk), .cs_n(cs_n), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] a, input logic [79:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    // MCP3008 device: captures start/SGL/D2..D0 on rising edges 1..5, drives B9..B0 after falling edges 6..15
    int         rcnt = 0;
    logic       prev_sclk = 1'b0;
    logic [4:0] shreg = '0;
    logic [4:0] last_cmd = '0;
    logic [9:0] adc_v = '0;
    always @(negedge clk) begin
        if (cs_n) begin
            rcnt = 0;
            dout = 1'b0;
        end else begin
            if (ad_clk && !prev_sclk) begin
                rcnt++;
                if (rcnt <= 5) shreg = {shreg[3:0], din};
                if (rcnt == 5) begin
                    last_cmd = shreg;
                    adc_v = vals[shreg[3:0]];
                end
            end
            if (!ad_clk && prev_sclk) dout = (rcnt >= 6 && rcnt <= 15) ? adc_v[15-rcnt] : 1'b0;
        end
        prev_sclk = ad_clk;
    end

    logic [2:0] r_ch [$];
    logic       r_src [$];
    logic [9:0] r_data [$];
    int cs_cur = 0, cs_len = 0;
    always @(negedge clk) begin
        if (rsp_valid) begin
            r_ch.push_back(rsp_ch);
            r_src.push_back(rsp_src);
            r_data.push_back(rsp_data);
        end
        if (!cs_n) cs_cur++;
        else if (cs_cur > 0) begin
            cs_len = cs_cur;
            cs_cur = 0;
        end
    end

    // reference: each acceptance at cycle t fixes the whole waveform relative to t
    int          cyc = 0, idle_at = 0, acc_t = 0, k = 0, j = 0;
    bit          act = 0, have_acc = 0, go = 0, found = 0;
    logic [2:0]  a_ch = '0, m_ptr = '0, l_ch = '0;
    logic        a_src = 1'b0, l_src = 1'b0;
    logic [4:0]  cbits = '0;
    logic [9:0]  a_val = '0, l_data = '0;
    logic [79:0] m_tab = '0;
    logic [7:0]  m_tv = '0;
    logic        e_cs, e_sclk, e_din, e_rv, e_ready, e_busy;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            act = 0; have_acc = 0; idle_at = cyc + 2; m_ptr = '0; m_tab = '0; m_tv = '0;
            l_ch = '0; l_data = '0; l_src = 1'b0;
        end
        e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0; e_rv = 1'b0;
        if (act) begin
            k = cyc - acc_t - 1;
            if (k < LOW) begin
                e_cs = 1'b0;
                e_sclk = (k >= CD) && (((k - CD) / CD) % 2 == 0);
                j = k / (2 * CD);
                e_din = (j < 5) ? cbits[4-j] : 1'b0;
            end
            if (k == LOW) begin
                e_rv = 1'b1; act = 0;
                l_ch = a_ch; l_data = a_val; l_src = a_src;
                if (!a_src) begin
                    m_tab[10*a_ch +: 10] = a_val;
                    m_tv[a_ch] = 1'b1;
                    m_ptr = 3'(a_ch + 3'd1);
                end
            end
        end
        e_ready = rst_n && (cyc >= idle_at);
        e_busy  = rst_n && have_acc && (cyc < idle_at);
        chk("cs_n", cs_n, e_cs);
        chk("ad_clk", ad_clk, e_sclk);
        chk("din", din, e_din);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("req_ready", req_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("rsp_ch", rsp_ch, l_ch);
        chk("rsp_data", rsp_data, l_data);
        chk("rsp_src", rsp_src, l_src);
        chk("scan_table", scan_table, m_tab);
        chk("scan_table_valid", scan_table_valid, m_tv);
        go = 0;
        if (e_ready) begin
            if (req_valid) begin
                go = 1; a_src = 1'b1; a_ch = req_ch; cbits = {1'b1, ~req_diff, req_ch};
            end else if (scan_en && ch_mask != 0) begin
                found = 0;
                for (int i = 0; i < 8; i++)
                    if (!found && ch_mask[(m_ptr + i) % 8]) begin
                        found = 1;
                        a_ch = 3'((m_ptr + i) % 8);
                    end
                go = 1; a_src = 1'b0; cbits = {2'b11, a_ch};
            end
        end
        if (go) begin
            act = 1; have_acc = 1; acc_t = cyc; a_val = vals[cbits[3:0]];
            idle_at = cyc + 1 + LOW + CSH;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] c, input logic d);
        bit ok = 0;
        req_ch = c; req_diff = d; req_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) tmo("request");
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (r_ch.size() >= n) ok = 1;
        end
        if (!ok) tmo("wait_resp");
        step();
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy && req_ready) ok = 1;
        end
        if (!ok) tmo("wait_idle");
        step();
    endtask

    int n, m, s1;
    initial begin
        rst_n = 1'b0; scan_en = 1'b0; ch_mask = '0; req_valid = 1'b0; req_ch = '0; req_diff = 1'b0;
        for (int i = 0; i < 16; i++) vals[i] = 10'(100 + (i % 8));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid_bits", scan_table_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", req_ready, 0);
        @(negedge clk);
        chk("ready_rise", req_ready, 1);
        step();

        vals[13] = 10'h2A7;
        n = r_ch.size();
        request(3'd5, 1'b0);
        wait_resp(n + 1);
        wait_idle();
        chk("t1_din_bits", last_cmd, 5'b11101);
        chk("t1_cs_low", cs_len, 66);
        chk("t1_rsp_count", r_ch.size(), n + 1);
        chk("t1_rsp_ch", r_ch[n], 5);
        chk("t1_rsp_data", r_data[n], 10'h2A7);
        chk("t1_rsp_src", r_src[n], 1);
        chk("t1_table", scan_table, 0);

        vals[13] = 10'd105;
        n = r_ch.size();
        scan_en = 1'b1; ch_mask = 8'hA1;
        wait_resp(n + 4);
        scan_en = 1'b0;
        wait_idle();
        chk("t2_order", {r_ch[n], r_ch[n+1], r_ch[n+2], r_ch[n+3]}, 12'b000_101_111_000);
        chk("t2_valid", scan_table_valid, 8'hA1);
        chk("t2_ch0", scan_table[9:0], 100);
        chk("t2_ch5", scan_table[59:50], 105);
        chk("t2_ch7", scan_table[79:70], 107);

        n = r_ch.size();
        scan_en = 1'b1;
        request(3'd3, 1'b0);
        wait_resp(n + 2);
        chk("t3_first", {r_src[n], r_ch[n]}, {1'b1, 3'd3});
        chk("t3_second", {r_src[n+1], r_ch[n+1]}, {1'b0, 3'd5});

        m = r_ch.size();
        begin
            bit ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (busy) ok = 1;
            end
            if (!ok) tmo("t4_busy");
            step();
        end
        request(3'd6, 1'b0);
        n = r_ch.size();
        wait_resp(n + 1);
        chk("t4_req_rsp", {r_src[n], r_ch[n]}, {1'b1, 3'd6});
        scan_en = 1'b0;
        wait_idle();
        s1 = 0;
        for (int i = m; i < r_ch.size(); i++) s1 += int'(r_src[i]);
        chk("t4_one_req", s1, 1);

        vals[2] = 10'h155;
        n = r_ch.size();
        request(3'd2, 1'b1);
        wait_resp(n + 1);
        wait_idle();
        chk("t5_din_bits", last_cmd, 5'b10010);
        chk("t5_rsp", {r_src[n], r_ch[n], r_data[n]}, {1'b1, 3'd2, 10'h155});

        scan_en = 1'b1; ch_mask = 8'hFF;
        begin
            bit ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (!cs_n) ok = 1;
            end
            if (!ok) tmo("t6_cs");
        end
        repeat (18) @(posedge clk);
        #3;
        chk("t6_sclk_high", ad_clk, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_cs", cs_n, 1);
        chk("t6_async_sclk", ad_clk, 0);
        chk("t6_async_din", din, 0);
        n = r_ch.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_valid_cleared", scan_table_valid, 0);
        chk("t6_table_cleared", scan_table, 0);
        wait_resp(n + 1);
        chk("t6_restart", {r_src[n], r_ch[n]}, {1'b0, 3'd0});
        chk("t6_valid_ch0", scan_table_valid, 8'h01);
        scan_en = 1'b0;
        wait_idle();

        for (int i = 0; i < 16; i++) vals[i] = 10'($urandom);
        repeat (40) begin
            scan_en = 1'($urandom_range(0, 1));
            ch_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 1) == 1) request(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 80)) @(posedge clk);
            #1;
        end
        scan_en = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
